// File: rtl/redun_mont_pkg.sv
// Shared widths and types for the redundant-form Montgomery datapath and its
// output-side carry resolver.
package redun_mont_pkg;

   localparam int NUM_WORDS  = 65;
   localparam int WORD_BITS  = 16;
   localparam int REDUN_BITS = 17;

   typedef logic [NUM_WORDS*REDUN_BITS-1:0] redun0_t;
   typedef logic [NUM_WORDS*WORD_BITS-1:0]  fe_t;
   typedef logic [REDUN_BITS-WORD_BITS:0]   collapse_carry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } collapse_state_t;

endpackage

// File: rtl/redun_collapse.sv
// Sequential carry resolver: turns a redundant digit vector into a plain binary
// integer, one output word per cycle, with valid/ready on both sides.
module redun_collapse
   import redun_mont_pkg::*;
#(
   parameter int NUM_WORDS  = redun_mont_pkg::NUM_WORDS,
   parameter int WORD_BITS  = redun_mont_pkg::WORD_BITS,
   parameter int REDUN_BITS = redun_mont_pkg::REDUN_BITS
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,
   input  logic [NUM_WORDS*REDUN_BITS-1:0]  i_redun,
   input  logic                             i_val,
   output logic                             o_rdy,
   output logic [NUM_WORDS*WORD_BITS-1:0]   o_dat,
   output logic                             o_overflow,
   output logic                             o_val,
   input  logic                             i_rdy
);

   localparam int CW = REDUN_BITS - WORD_BITS + 1;
   localparam int SW = REDUN_BITS + 1;
   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

   collapse_state_t                  state_q,  state_d;
   logic [NUM_WORDS*REDUN_BITS-1:0]  digits_q, digits_d;
   logic [CW-1:0]                    carry_q,  carry_d;
   logic [IW-1:0]                    idx_q,    idx_d;
   logic [NUM_WORDS*WORD_BITS-1:0]   dat_q,    dat_d;
   logic                             ovf_q,    ovf_d;
   logic                             rdy_q,    rdy_d;
   logic                             val_q,    val_d;
   logic [SW-1:0]                    sum_s;

   // Next-state logic; the digit register shifts down so the active digit is always at the bottom.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      dat_d    = dat_q;
      ovf_d    = ovf_q;
      rdy_d    = rdy_q;
      val_d    = val_q;
      sum_s    = {1'b0, digits_q[REDUN_BITS-1:0]} + SW'(carry_q);
      case (state_q)
         IDLE: begin
            if (i_val && rdy_q) begin
               state_d  = RUN;
               digits_d = i_redun;
               carry_d  = '0;
               idx_d    = '0;
               rdy_d    = 1'b0;
            end else begin
               rdy_d    = 1'b1;
            end
         end
         RUN: begin
            digits_d = digits_q >> REDUN_BITS;
            dat_d[idx_q*WORD_BITS +: WORD_BITS] = sum_s[WORD_BITS-1:0];
            carry_d  = CW'(sum_s >> WORD_BITS);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               ovf_d   = |sum_s[SW-1:WORD_BITS];
               val_d   = 1'b1;
            end else begin
               idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            if (i_rdy) begin
               state_d = IDLE;
               val_d   = 1'b0;
               rdy_d   = 1'b1;
            end else begin
               val_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            val_d   = 1'b0;
            rdy_d   = 1'b1;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         digits_q <= '0;
         carry_q  <= '0;
         idx_q    <= '0;
         dat_q    <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b1;
         val_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         dat_q    <= dat_d;
         ovf_q    <= ovf_d;
         rdy_q    <= rdy_d;
         val_q    <= val_d;
      end
   end

   assign o_rdy      = rdy_q;
   assign o_val      = val_q;
   assign o_dat      = dat_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_redun_collapse.sv
// Directed plus randomized bench for redun_collapse, checked against an
// integer-sum reference model of the redundant encoding.
module tb_redun_collapse;
   import redun_mont_pkg::*;

   localparam int NW  = NUM_WORDS;
   localparam int WB  = WORD_BITS;
   localparam int RB  = REDUN_BITS;
   localparam int ACCW = NW*WB + RB + 8;

   logic    i_clk = 1'b0;
   logic    i_reset_n = 1'b0;
   redun0_t i_redun = '0;
   logic    i_val = 1'b0;
   logic    o_rdy;
   fe_t     o_dat;
   logic    o_overflow;
   logic    o_val;
   logic    i_rdy = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   redun_collapse dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_redun    (i_redun),
      .i_val      (i_val),
      .o_rdy      (o_rdy),
      .o_dat      (o_dat),
      .o_overflow (o_overflow),
      .o_val      (o_val),
      .i_rdy      (i_rdy)
   );

   always #5 i_clk = ~i_clk;

   // Value of a redundant vector is sum(digit_k * 2^(WB*k)); split into low field and excess.
   function automatic void model(input redun0_t r, output fe_t d, output logic ov);
      logic [ACCW-1:0] acc;
      acc = '0;
      for (int k = 0; k < NW; k++)
         acc = acc + (ACCW'(r[k*RB +: RB]) << (k*WB));
      d  = acc[NW*WB-1:0];
      ov = |acc[ACCW-1:NW*WB];
   endfunction

   // Random valid redundant encoding of a: borrow 2^WB into a digit from the next one up.
   function automatic redun0_t to_redun(input fe_t a);
      redun0_t r;
      int b_prev, b, w, d;
      r = '0;
      b_prev = 0;
      for (int k = 0; k < NW; k++) begin
         w = int'(a[k*WB +: WB]);
         b = (k == NW-1) ? 0 : int'($urandom_range(0, 1));
         if (w - b_prev < 0) b = 1;
         d = w + b*(1 << WB) - b_prev;
         r[k*RB +: RB] = RB'(d);
         b_prev = b;
      end
      return r;
   endfunction

   task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dat(input string tag, input fe_t obs, input fe_t exp);
      int k;
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         k = 0;
         while (k < NW-1 && obs[k*WB +: WB] === exp[k*WB +: WB]) k++;
         $error("FAIL %s: word %0d observed %0h expected %0h", tag, k, obs[k*WB +: WB], exp[k*WB +: WB]);
      end
   endtask

   task automatic accept(input redun0_t r);
      int guard;
      guard = 0;
      while (!o_rdy && guard < 200) begin
         @(posedge i_clk); #1;
         guard++;
      end
      i_redun = r;
      i_val   = 1'b1;
      @(posedge i_clk); #1;
      i_val   = 1'b0;
   endtask

   task automatic wait_val(output int lat);
      lat = 0;
      while (!o_val && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
   endtask

   task automatic convert(input string tag, input redun0_t r);
      fe_t  ed;
      logic eo;
      int   lat;
      model(r, ed, eo);
      accept(r);
      wait_val(lat);
      chk1({tag, "_lat"}, 32'(lat), 32'(NW));
      chk_dat({tag, "_dat"}, o_dat, ed);
      chk1({tag, "_ovf"}, 32'(o_overflow), 32'(eo));
   endtask

   initial begin
      redun0_t r, y;
      fe_t     a, snap, ed;
      logic    snap_ovf, eo;
      int      lat;

      #12;
      chk1("rst_rdy", 32'(o_rdy), 32'd1);
      chk1("rst_val", 32'(o_val), 32'd0);
      chk1("rst_ovf", 32'(o_overflow), 32'd0);
      chk_dat("rst_dat", o_dat, '0);
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;

      // All-zero input, with o_rdy dropping on the accept edge
      accept('0);
      chk1("zero_rdy_low", 32'(o_rdy), 32'd0);
      wait_val(lat);
      chk1("zero_lat", 32'(lat), 32'd65);
      chk_dat("zero_dat", o_dat, '0);
      chk1("zero_ovf", 32'(o_overflow), 32'd0);
      @(posedge i_clk); #1;

      // Single-digit carry
      r = '0;
      r[RB-1:0] = 17'h1FFFF;
      convert("one", r);
      chk1("one_w0", 32'(o_dat[WB-1:0]), 32'h0000FFFF);
      chk1("one_w1", 32'(o_dat[2*WB-1:WB]), 32'h00000001);
      @(posedge i_clk); #1;

      // All digits at maximum: final carry of 2
      for (int k = 0; k < NW; k++) r[k*RB +: RB] = 17'h1FFFF;
      convert("max", r);
      chk1("max_w0", 32'(o_dat[WB-1:0]), 32'h0000FFFF);
      chk1("max_w1", 32'(o_dat[2*WB-1:WB]), 32'h00000000);
      chk1("max_w64", 32'(o_dat[64*WB +: WB]), 32'h00000001);
      chk1("max_ovf1", 32'(o_overflow), 32'd1);
      @(posedge i_clk); #1;

      // Arbitrary random digits
      for (int v = 0; v < 10; v++) begin
         for (int k = 0; k < NW; k++) r[k*RB +: RB] = RB'($urandom);
         convert("rand", r);
         @(posedge i_clk); #1;
      end

      // Round-trip: binary -> redundant -> binary
      for (int v = 0; v < 1000; v++) begin
         for (int k = 0; k < NW; k++) a[k*WB +: WB] = WB'($urandom);
         a[(NW-1)*WB +: WB] = WB'($urandom_range(1, 16'h7FFF));
         accept(to_redun(a));
         wait_val(lat);
         chk1("rt_lat", 32'(lat), 32'(NW));
         chk_dat("rt_dat", o_dat, a);
         chk1("rt_ovf", 32'(o_overflow), 32'd0);
         @(posedge i_clk); #1;
      end

      // Back-pressure with a competing i_val held through DONE and the handshake edge
      i_rdy = 1'b0;
      for (int k = 0; k < NW; k++) r[k*RB +: RB] = RB'($urandom);
      for (int k = 0; k < NW; k++) y[k*RB +: RB] = RB'($urandom);
      model(r, ed, eo);
      accept(r);
      wait_val(lat);
      chk1("bp_lat", 32'(lat), 32'(NW));
      chk_dat("bp_dat", o_dat, ed);
      snap = o_dat;
      snap_ovf = o_overflow;
      i_redun = y;
      i_val = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge i_clk); #1;
         chk1("bp_val_hold", 32'(o_val), 32'd1);
         chk1("bp_rdy_low", 32'(o_rdy), 32'd0);
         chk_dat("bp_dat_hold", o_dat, snap);
         chk1("bp_ovf_hold", 32'(o_overflow), 32'(snap_ovf));
      end
      i_rdy = 1'b1;
      @(posedge i_clk); #1;
      chk1("hs_val_low", 32'(o_val), 32'd0);
      chk1("hs_rdy_high", 32'(o_rdy), 32'd1);
      @(posedge i_clk); #1;
      i_val = 1'b0;
      chk1("late_accept_rdy", 32'(o_rdy), 32'd0);
      model(y, ed, eo);
      wait_val(lat);
      chk1("late_lat", 32'(lat), 32'(NW));
      chk_dat("late_dat", o_dat, ed);
      chk1("late_ovf", 32'(o_overflow), 32'(eo));
      @(posedge i_clk); #1;

      // Reset in the middle of RUN, then a clean conversion
      for (int k = 0; k < NW; k++) r[k*RB +: RB] = 17'h1FFFF;
      accept(r);
      repeat (30) @(posedge i_clk);
      #3 i_reset_n = 1'b0;
      #1;
      chk1("mid_rst_rdy", 32'(o_rdy), 32'd1);
      chk1("mid_rst_val", 32'(o_val), 32'd0);
      chk1("mid_rst_ovf", 32'(o_overflow), 32'd0);
      chk_dat("mid_rst_dat", o_dat, '0);
      #2 i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      r = '0;
      r[RB-1:0] = 17'h00005;
      convert("post_rst", r);
      chk1("post_rst_w0", 32'(o_dat[WB-1:0]), 32'h00000005);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
